// File: rtl/regfile_dbg_port.sv
// Debug port giving a halted core's debugger read/write/dump access to the register file.
// Optional full-register dump is built when REGFILE_DBG_DUMP_EN is defined.
module regfile_dbg_port #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned NUM_REGISTERS  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      core_halted,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [1:0]                cmd_op,
    input  logic [REG_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0]     cmd_wdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [REG_ADDR_WIDTH-1:0] rsp_addr,
    output logic [DATA_WIDTH-1:0]     rsp_data,
    output logic                      rsp_err,
    output logic                      rsp_last,
    output logic                      rf_read_enable,
    output logic [REG_ADDR_WIDTH-1:0] rf_rs1_addr,
    input  logic [DATA_WIDTH-1:0]     rf_rs1,
    output logic                      rf_write_enable,
    output logic [REG_ADDR_WIDTH-1:0] rf_write_addr,
    output logic [DATA_WIDTH-1:0]     rf_write_data
);

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StWrite,
        StDumpRd,
        StResp
    } state_t;

    localparam logic [1:0] OpRead  = 2'b00;
    localparam logic [1:0] OpWrite = 2'b01;
`ifdef REGFILE_DBG_DUMP_EN
    localparam logic [1:0] OpDump  = 2'b10;
    localparam logic [REG_ADDR_WIDTH-1:0] LastIdx = REG_ADDR_WIDTH'(NUM_REGISTERS - 1);
`endif

    // The index space must be able to name every register.
    if (NUM_REGISTERS > (1 << REG_ADDR_WIDTH)) begin : g_bad_cfg
        $error("NUM_REGISTERS exceeds REG_ADDR_WIDTH index space");
    end

    state_t                    r_state;
    logic [REG_ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0]     r_wdata;
`ifdef REGFILE_DBG_DUMP_EN
    logic [REG_ADDR_WIDTH-1:0] r_idx;
`endif
    logic                      r_rsp_valid;
    logic [REG_ADDR_WIDTH-1:0] r_rsp_addr;
    logic [DATA_WIDTH-1:0]     r_rsp_data;
    logic                      r_rsp_err;
    logic                      r_rsp_last;

    logic w_accept;
    logic w_addr_zero;

    assign cmd_ready   = (r_state == StIdle) && core_halted;
    assign w_accept    = cmd_valid && cmd_ready;
    assign w_addr_zero = (r_addr == '0);

    assign rsp_valid = r_rsp_valid;
    assign rsp_addr  = r_rsp_addr;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;
    assign rsp_last  = r_rsp_last;

    // Register file strobes decode straight from the registered state.
    always_comb begin
        rf_read_enable  = 1'b0;
        rf_rs1_addr     = '0;
        rf_write_enable = 1'b0;
        rf_write_addr   = '0;
        rf_write_data   = '0;
        case (r_state)
            StRead: begin
                rf_read_enable = 1'b1;
                rf_rs1_addr    = r_addr;
            end
`ifdef REGFILE_DBG_DUMP_EN
            StDumpRd: begin
                rf_read_enable = 1'b1;
                rf_rs1_addr    = r_idx;
            end
`endif
            StWrite: begin
                if (!w_addr_zero) begin
                    rf_write_enable = 1'b1;
                    rf_write_addr   = r_addr;
                    rf_write_data   = r_wdata;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_addr      <= '0;
            r_wdata     <= '0;
`ifdef REGFILE_DBG_DUMP_EN
            r_idx       <= '0;
`endif
            r_rsp_valid <= 1'b0;
            r_rsp_addr  <= '0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_last  <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_addr  <= cmd_addr;
                        r_wdata <= cmd_wdata;
                        case (cmd_op)
                            OpRead:  r_state <= StRead;
                            OpWrite: r_state <= StWrite;
`ifdef REGFILE_DBG_DUMP_EN
                            OpDump: begin
                                r_idx   <= '0;
                                r_state <= StDumpRd;
                            end
`endif
                            default: begin
                                r_rsp_valid <= 1'b1;
                                r_rsp_addr  <= cmd_addr;
                                r_rsp_data  <= '0;
                                r_rsp_err   <= 1'b1;
                                r_rsp_last  <= 1'b1;
                                r_state     <= StResp;
                            end
                        endcase
                    end
                end
                StRead: begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_addr  <= r_addr;
                    r_rsp_data  <= rf_rs1;
                    r_rsp_err   <= 1'b0;
                    r_rsp_last  <= 1'b1;
                    r_state     <= StResp;
                end
                StWrite: begin
                    // x0 is hardwired: no strobe, report the write as rejected.
                    r_rsp_valid <= 1'b1;
                    r_rsp_addr  <= r_addr;
                    r_rsp_data  <= w_addr_zero ? '0 : r_wdata;
                    r_rsp_err   <= w_addr_zero;
                    r_rsp_last  <= 1'b1;
                    r_state     <= StResp;
                end
`ifdef REGFILE_DBG_DUMP_EN
                StDumpRd: begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_addr  <= r_idx;
                    r_rsp_data  <= rf_rs1;
                    r_rsp_err   <= 1'b0;
                    r_rsp_last  <= (r_idx == LastIdx);
                    r_state     <= StResp;
                end
`endif
                StResp: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_addr  <= '0;
                        r_rsp_data  <= '0;
                        r_rsp_err   <= 1'b0;
                        r_rsp_last  <= 1'b0;
`ifdef REGFILE_DBG_DUMP_EN
                        if (r_rsp_last) begin
                            r_state <= StIdle;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_state <= StDumpRd;
                        end
`else
                        r_state <= StIdle;
`endif
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dbg_port.sv
// Directed bench for regfile_dbg_port with a behavioural register file model.
// Dump checks follow REGFILE_DBG_DUMP_EN the same way the design does.
module tb_regfile_dbg_port;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          core_halted;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [AW-1:0] rsp_addr;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic          rsp_last;
    logic          rf_read_enable;
    logic [AW-1:0] rf_rs1_addr;
    logic [DW-1:0] rf_rs1;
    logic          rf_write_enable;
    logic [AW-1:0] rf_write_addr;
    logic [DW-1:0] rf_write_data;

    always #5 clk = ~clk;

    regfile_dbg_port #(
        .DATA_WIDTH    (DW),
        .REG_ADDR_WIDTH(AW),
        .NUM_REGISTERS (NR)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .core_halted    (core_halted),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_addr       (cmd_addr),
        .cmd_wdata      (cmd_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_addr       (rsp_addr),
        .rsp_data       (rsp_data),
        .rsp_err        (rsp_err),
        .rsp_last       (rsp_last),
        .rf_read_enable (rf_read_enable),
        .rf_rs1_addr    (rf_rs1_addr),
        .rf_rs1         (rf_rs1),
        .rf_write_enable(rf_write_enable),
        .rf_write_addr  (rf_write_addr),
        .rf_write_data  (rf_write_data)
    );

    // Register file model, cleared once at start of the run.
    logic          mem_clr;
    logic [DW-1:0] mem [NR];
    assign rf_rs1 = mem[rf_rs1_addr];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < NR; i++) mem[i] <= '0;
        end else if (rf_write_enable) begin
            mem[rf_write_addr] <= rf_write_data;
        end
    end

    int n_we;
    int n_act;
    int n_vld;
    always @(posedge clk) begin
        if (rf_write_enable) n_we <= n_we + 1;
        if (rf_read_enable || rf_write_enable) n_act <= n_act + 1;
        if (rsp_valid) n_vld <= n_vld + 1;
    end

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(input string tag);
        int n = 0;
        while (!rsp_valid && n < 20) begin
            tick();
            n++;
        end
        check_eq(tag, 64'(rsp_valid), 64'd1);
    endtask

    task automatic issue(input logic [1:0] op, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_wdata = wd;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd, output logic [DW-1:0] data,
                          output logic err, output logic last);
        issue(op, addr, wd);
        wait_rsp("do_cmd_rsp");
        data = rsp_data;
        err  = rsp_err;
        last = rsp_last;
        handshake();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] d;
        logic          e;
        logic          l;
        int            w0;
        int            a0;
        int            v0;

        rst         = 1'b1;
        mem_clr     = 1'b1;
        core_halted = 1'b0;
        cmd_valid   = 1'b0;
        cmd_op      = '0;
        cmd_addr    = '0;
        cmd_wdata   = '0;
        rsp_ready   = 1'b0;
        repeat (3) tick();
        rst     = 1'b0;
        mem_clr = 1'b0;
        tick();

        // Reset state
        check_eq("rst_flags", 64'({rsp_valid, rsp_err, rsp_last, rf_read_enable, rf_write_enable}),
                 64'd0);
        check_eq("rst_data", 64'({rsp_data, rf_write_data}), 64'd0);
        check_eq("rst_addr", 64'({rsp_addr, rf_rs1_addr, rf_write_addr}), 64'd0);
        check_eq("rst_ready_running", 64'(cmd_ready), 64'd0);
        core_halted = 1'b1;
        #1;
        check_eq("rst_ready_halted", 64'(cmd_ready), 64'd1);

        // Core running: nothing accepted, no register file traffic
        core_halted = 1'b0;
        cmd_op      = 2'b01;
        cmd_addr    = 5'd3;
        cmd_wdata   = 32'hAA;
        cmd_valid   = 1'b1;
        #1;
        check_eq("run_ready", 64'(cmd_ready), 64'd0);
        a0 = n_act;
        v0 = n_vld;
        repeat (4) tick();
        check_eq("run_no_act", 64'(n_act - a0), 64'd0);
        check_eq("run_no_rsp", 64'(n_vld - v0), 64'd0);
        cmd_valid   = 1'b0;
        core_halted = 1'b1;
        tick();

        // Write x5 with exact timing
        w0 = n_we;
        issue(2'b01, 5'd5, 32'hDEADBEEF);
        check_eq("wr_strobe", 64'(rf_write_enable), 64'd1);
        check_eq("wr_addr", 64'(rf_write_addr), 64'd5);
        check_eq("wr_data", 64'(rf_write_data), 64'hDEADBEEF);
        check_eq("wr_rsp_early", 64'(rsp_valid), 64'd0);
        tick();
        check_eq("wr_strobe_off", 64'(rf_write_enable), 64'd0);
        check_eq("wr_rsp_valid", 64'(rsp_valid), 64'd1);
        check_eq("wr_rsp_data", 64'(rsp_data), 64'hDEADBEEF);
        check_eq("wr_rsp_flags", 64'({rsp_err, rsp_last}), 64'b01);
        check_eq("wr_rsp_addr", 64'(rsp_addr), 64'd5);
        check_eq("wr_one_pulse", 64'(n_we - w0), 64'd1);
        handshake();
        check_eq("wr_rsp_done", 64'(rsp_valid), 64'd0);

        // Read x5 with response back-pressure
        issue(2'b00, 5'd5, 32'h0);
        check_eq("rd_en", 64'(rf_read_enable), 64'd1);
        check_eq("rd_addr", 64'(rf_rs1_addr), 64'd5);
        check_eq("rd_rsp_early", 64'(rsp_valid), 64'd0);
        tick();
        check_eq("rd_en_off", 64'(rf_read_enable), 64'd0);
        check_eq("rd_rsp_valid", 64'(rsp_valid), 64'd1);
        check_eq("rd_rsp_data", 64'(rsp_data), 64'hDEADBEEF);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("rd_hold", 64'({rsp_valid, rsp_last, rsp_err, rsp_addr, rsp_data}),
                     64'({1'b1, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF}));
        end
        handshake();
        check_eq("rd_done_valid", 64'(rsp_valid), 64'd0);
        check_eq("rd_done_idle", 64'(cmd_ready), 64'd1);

        // Write to x0 is rejected, read x0 gives zero
        w0 = n_we;
        do_cmd(2'b01, 5'd0, 32'h1234, d, e, l);
        check_eq("x0_wr_data", 64'(d), 64'd0);
        check_eq("x0_wr_flags", 64'({e, l}), 64'b11);
        check_eq("x0_no_strobe", 64'(n_we - w0), 64'd0);
        do_cmd(2'b00, 5'd0, 32'h0, d, e, l);
        check_eq("x0_rd_data", 64'(d), 64'd0);
        check_eq("x0_rd_flags", 64'({e, l}), 64'b01);

        // Halt dropping after acceptance does not abort the command
        issue(2'b00, 5'd5, 32'h0);
        core_halted = 1'b0;
        wait_rsp("halt_drop_rsp");
        check_eq("halt_drop_data", 64'(rsp_data), 64'hDEADBEEF);
        handshake();
        check_eq("halt_drop_ready", 64'(cmd_ready), 64'd0);
        core_halted = 1'b1;

        // Reserved op
        do_cmd(2'b11, 5'd7, 32'h55, d, e, l);
        check_eq("rsv_data", 64'(d), 64'd0);
        check_eq("rsv_flags", 64'({e, l}), 64'b11);
        v0 = n_vld;
        repeat (3) tick();
        check_eq("rsv_single", 64'(n_vld - v0), 64'd0);

`ifdef REGFILE_DBG_DUMP_EN
        for (int i = 1; i < NR; i++) begin
            do_cmd(2'b01, AW'(i), DW'(i * 32'h11), d, e, l);
        end
        issue(2'b10, 5'd0, 32'h0);
        for (int b = 0; b < NR; b++) begin
            logic [DW-1:0] snap;
            int            stall;
            wait_rsp("dump_rsp");
            check_eq("dump_addr", 64'(rsp_addr), 64'(b));
            check_eq("dump_data", 64'(rsp_data), 64'(b * 32'h11));
            check_eq("dump_last", 64'({rsp_err, rsp_last}), 64'({1'b0, b == NR - 1}));
            snap  = rsp_data;
            stall = $urandom_range(0, 3);
            for (int s = 0; s < stall; s++) tick();
            check_eq("dump_hold", 64'({rsp_valid, rsp_data}), 64'({1'b1, snap}));
            handshake();
        end
        check_eq("dump_end_valid", 64'(rsp_valid), 64'd0);
        check_eq("dump_end_idle", 64'(cmd_ready), 64'd1);

        // Reset during dump beat 7
        issue(2'b10, 5'd0, 32'h0);
        for (int b = 0; b < 7; b++) begin
            wait_rsp("dump2_rsp");
            handshake();
        end
        wait_rsp("dump2_beat7");
        check_eq("dump2_addr7", 64'(rsp_addr), 64'd7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("dump2_rst_valid", 64'(rsp_valid), 64'd0);
        v0 = n_vld;
        a0 = n_act;
        repeat (40) tick();
        check_eq("dump2_no_beats", 64'(n_vld - v0), 64'd0);
        check_eq("dump2_no_act", 64'(n_act - a0), 64'd0);
        check_eq("dump2_idle", 64'(cmd_ready), 64'd1);
`else
        do_cmd(2'b10, 5'd4, 32'h0, d, e, l);
        check_eq("nodump_data", 64'(d), 64'd0);
        check_eq("nodump_flags", 64'({e, l}), 64'b11);
        v0 = n_vld;
        a0 = n_act;
        repeat (10) tick();
        check_eq("nodump_single", 64'(n_vld - v0), 64'd0);
        check_eq("nodump_no_act", 64'(n_act - a0), 64'd0);
`endif

        // Reset during a read aborts it
        issue(2'b00, 5'd5, 32'h0);
        check_eq("rstrd_in_read", 64'(rf_read_enable), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rstrd_valid", 64'(rsp_valid), 64'd0);
        v0 = n_vld;
        repeat (5) tick();
        check_eq("rstrd_no_beat", 64'(n_vld - v0), 64'd0);
        check_eq("rstrd_idle", 64'(cmd_ready), 64'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
